// File: rtl/led_driver_multi.sv
// led_driver_multi: streams framebuffer words onto several parallel LED-driver
// shift-register chains that share one shift clock and one latch line.
// A free-running frame timer paces the frames. The first frames after reset
// are all-zero blank frames. A frame start that arrives while the previous
// frame is still running is skipped and flagged on o_overrun.
module led_driver_multi #(
  parameter int c_chains           = 4,
  parameter int c_boards_per_chain = 8,
  parameter int c_bpc              = 12,
  parameter int c_frame_period     = 16666,
  parameter int c_blank_frames     = 2
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_en,
  input  logic [c_chains*c_bpc-1:0]                 i_data,
  output logic [$clog2(c_boards_per_chain*32)-1:0]  o_addr,
  output logic                                      o_clk,
  output logic [c_chains-1:0]                       o_dai,
  output logic                                      o_lat,
  output logic                                      o_ready,
  output logic                                      o_drq,
  output logic                                      o_overrun
);

  localparam int C   = c_boards_per_chain * 32;
  localparam int AW  = $clog2(C);
  localparam int CW  = (c_frame_period > 1) ? $clog2(c_frame_period) : 1;
  localparam int BW  = (c_bpc > 1) ? $clog2(c_bpc) : 1;
  localparam int BLW = (c_blank_frames > 0) ? $clog2(c_blank_frames + 1) : 1;

  localparam logic [AW-1:0]  C_LAST     = AW'(C - 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(c_frame_period - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(c_bpc - 1);
  localparam logic [BLW-1:0] BLANK_INIT = BLW'(c_blank_frames);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_SHIFT,
    S_LATCH
  } state_e;

  state_e                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [CW-1:0]                  cnt_d;
  logic [AW-1:0]                  n_q;
  logic [BW-1:0]                  bit_q;
  logic                           phase_q;
  logic [BLW-1:0]                 blank_q;
  logic [c_chains-1:0][c_bpc-1:0] sreg_q;

  logic [AW-1:0]                  addr_q;
  logic                           clk_q;
  logic [c_chains-1:0]            dai_q;
  logic                           lat_q;
  logic                           ready_q;
  logic                           drq_q;
  logic                           ovr_q;

  logic                           start_ev;

  assign start_ev  = i_en && (cnt_q == '0);

  assign o_addr    = addr_q;
  assign o_clk     = clk_q;
  assign o_dai     = dai_q;
  assign o_lat     = lat_q;
  assign o_ready   = ready_q;
  assign o_drq     = drq_q;
  assign o_overrun = ovr_q;

  // Next value of the free-running frame timer, wrapping at the frame period
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
  end

  // Frame timer register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Frame sequencer: walks channels top-down, shifts each word MSB first, then latches
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      blank_q <= BLANK_INIT;
      sreg_q  <= '0;
      addr_q  <= '0;
      clk_q   <= 1'b0;
      dai_q   <= '0;
      lat_q   <= 1'b0;
      ready_q <= 1'b0;
      drq_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      lat_q <= 1'b0;
      drq_q <= 1'b0;
      ovr_q <= start_ev && (state_q != S_IDLE);
      if (blank_q == '0) begin
        ready_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            state_q <= S_ADDR;
            n_q     <= C_LAST;
            addr_q  <= C_LAST;
          end
        end

        S_ADDR: begin
          state_q <= S_CAPT;
        end

        S_CAPT: begin
          state_q <= S_SHIFT;
          bit_q   <= BIT_LAST;
          phase_q <= 1'b0;
          clk_q   <= 1'b0;
          for (int k = 0; k < c_chains; k++) begin
            if (blank_q != '0) begin
              sreg_q[k] <= '0;
              dai_q[k]  <= 1'b0;
            end else begin
              sreg_q[k] <= i_data[k*c_bpc +: c_bpc] << 1;
              dai_q[k]  <= i_data[k*c_bpc + c_bpc - 1];
            end
          end
        end

        S_SHIFT: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            clk_q   <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            clk_q   <= 1'b0;
            if (bit_q != '0) begin
              bit_q <= bit_q - BW'(1);
              for (int k = 0; k < c_chains; k++) begin
                dai_q[k]  <= sreg_q[k][c_bpc-1];
                sreg_q[k] <= sreg_q[k] << 1;
              end
            end else if (n_q != '0) begin
              state_q <= S_ADDR;
              n_q     <= n_q - AW'(1);
              addr_q  <= n_q - AW'(1);
              dai_q   <= '0;
            end else begin
              state_q <= S_LATCH;
              addr_q  <= '0;
              dai_q   <= '0;
              lat_q   <= 1'b1;
              drq_q   <= (blank_q == '0);
            end
          end
        end

        S_LATCH: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            if (blank_q != '0) begin
              blank_q <= blank_q - BLW'(1);
              if (blank_q == BLW'(1)) begin
                ready_q <= 1'b1;
              end
            end
          end else begin
            phase_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_driver_multi.sv
// tb_led_driver_multi: two instances of the LED driver, one with a relaxed frame
// period and two blank frames, one with a too-short period and no blank frames.
// A frame-offset model predicts every output on every cycle.
module tb_led_driver_multi;

  localparam int NCH   = 2;
  localparam int BPC   = 4;
  localparam int C     = 32;
  localparam int AW    = 5;
  localparam int DW    = NCH * BPC;
  localparam int L     = 2 + 2 * BPC;
  localparam int CL    = C * L;
  localparam int FRAME = CL + 2;
  localparam int P0    = 400;
  localparam int P1    = 300;
  localparam int B0    = 2;
  localparam int B1    = 0;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          en    = 1'b1;
  logic [DW-1:0] mem   [C];
  logic [DW-1:0] iData [2];
  logic [AW-1:0] oAddr [2];
  logic          oClk  [2];
  logic [NCH-1:0] oDai [2];
  logic          oLat  [2];
  logic          oReady[2];
  logic          oDrq  [2];
  logic          oOvr  [2];

  int            checks = 0;
  int            errors = 0;
  bit            cmpOn  = 1'b0;

  int            mCnt   [2];
  int            mOff   [2];
  int            mBlank [2];
  bit            mActive[2];
  bit            mReady [2];
  bit            mOvr   [2];
  int            period [2] = '{P0, P1};
  int            blankN [2] = '{B0, B1};

  logic [11:0]   expV;
  logic [11:0]   actV;

  led_driver_multi #(
    .c_chains(NCH), .c_boards_per_chain(1), .c_bpc(BPC),
    .c_frame_period(P0), .c_blank_frames(B0)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(iData[0]),
    .o_addr(oAddr[0]), .o_clk(oClk[0]), .o_dai(oDai[0]), .o_lat(oLat[0]),
    .o_ready(oReady[0]), .o_drq(oDrq[0]), .o_overrun(oOvr[0])
  );

  led_driver_multi #(
    .c_chains(NCH), .c_boards_per_chain(1), .c_bpc(BPC),
    .c_frame_period(P1), .c_blank_frames(B1)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(iData[1]),
    .o_addr(oAddr[1]), .o_clk(oClk[1]), .o_dai(oDai[1]), .o_lat(oLat[1]),
    .o_ready(oReady[1]), .o_drq(oDrq[1]), .o_overrun(oOvr[1])
  );

  always #5 clk = ~clk;

  // Framebuffer RAMs: synchronous read with one cycle of latency
  always @(posedge clk) begin
    iData[0] <= mem[oAddr[0]];
    iData[1] <= mem[oAddr[1]];
  end

  // Reference model: tracks the timer, whether a frame runs and how far into it we are
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mCnt[i]    = 0;
        mOff[i]    = 0;
        mActive[i] = 1'b0;
        mBlank[i]  = blankN[i];
        mReady[i]  = 1'b0;
        mOvr[i]    = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mOvr[i] = (mCnt[i] == 0) && en && mActive[i];
        if (mActive[i]) begin
          if (mOff[i] == CL && mBlank[i] > 0) mBlank[i] = mBlank[i] - 1;
          mOff[i] = mOff[i] + 1;
          if (mOff[i] == FRAME) mActive[i] = 1'b0;
        end else if ((mCnt[i] == 0) && en) begin
          mActive[i] = 1'b1;
          mOff[i]    = 0;
        end
        mCnt[i] = (mCnt[i] + 1) % period[i];
        if (mBlank[i] == 0) mReady[i] = 1'b1;
      end
    end
  end

  // Expected {addr, clk, dai, lat, ready, drq, overrun} from the frame offset alone
  function automatic logic [11:0] expOut(input int i);
    logic [AW-1:0]  a;
    logic           c;
    logic [NCH-1:0] d;
    logic           l;
    logic           q;
    logic [DW-1:0]  w;
    int             j, r, n, b;
    a = '0; c = 1'b0; d = '0; l = 1'b0; q = 1'b0;
    if (mActive[i]) begin
      if (mOff[i] < CL) begin
        j = mOff[i] / L;
        r = mOff[i] % L;
        n = C - 1 - j;
        a = AW'(n);
        if (r >= 2) begin
          b = BPC - 1 - (r - 2) / 2;
          c = ((r - 2) % 2) == 1;
          w = mem[n];
          if (mBlank[i] == 0) begin
            for (int k = 0; k < NCH; k++) d[k] = w[k*BPC + b];
          end
        end
      end else if (mOff[i] == CL) begin
        l = 1'b1;
        q = (mBlank[i] == 0);
      end
    end
    return {a, c, d, l, mReady[i], q, mOvr[i]};
  endfunction

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmpOn) begin
      for (int i = 0; i < 2; i++) begin
        expV = expOut(i);
        actV = {oAddr[i], oClk[i], oDai[i], oLat[i], oReady[i], oDrq[i], oOvr[i]};
        checks++;
        if (actV !== expV) begin
          errors++;
          $display("[TB] FAIL cycle_dut%0d at %0t: got %h required %h (addr,clk,dai,lat,ready,drq,ovr)",
                   i, $time, actV, expV);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic enV);
    en = enV;
    @(negedge clk);
  endtask

  // mode 0: constant 8'hA5, mode 1: {addr, ~addr}, mode 2: random words
  task automatic doReset(input int mode);
    logic [3:0] a4;
    @(negedge clk);
    #1 rst_n = 1'b0;
    cmpOn = 1'b1;
    #1;
    checkOutput("rst_zero_dut0", {oAddr[0], oClk[0], oDai[0], oLat[0], oReady[0], oDrq[0], oOvr[0]}, 0);
    checkOutput("rst_zero_dut1", {oAddr[1], oClk[1], oDai[1], oLat[1], oReady[1], oDrq[1], oOvr[1]}, 0);
    for (int a = 0; a < C; a++) begin
      a4 = 4'(a);
      if (mode == 0)      mem[a] = 8'hA5;
      else if (mode == 1) mem[a] = {a4, ~a4};
      else                mem[a] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         latN, drqEarly, nBits, tA, tL, tO, tA2, tR, clkSeen;
    logic [3:0] bits0, bits1;
    logic       prevLat, enR;
    logic [AW-1:0] prevAddr1;
    bit         found;

    // Blank start-up frames with constant data, then the first real frame
    en = 1'b1;
    doReset(0);
    latN = 0; drqEarly = 0; nBits = 0; bits0 = '0; bits1 = '0; prevLat = 1'b0;
    for (int cyc = 0; cyc < 2000 && latN < 3; cyc++) begin
      applyStimulus(1'b1);
      if (prevLat && latN == 2) checkOutput("ready_after_2nd_lat", oReady[0], 1);
      if (oLat[0]) begin
        latN++;
        if (latN == 2) checkOutput("ready_during_2nd_lat", oReady[0], 0);
        if (latN == 3) checkOutput("drq_with_3rd_lat", oDrq[0], 1);
      end
      if (oDrq[0] && latN < 3) drqEarly++;
      if (latN == 2 && oClk[0] && nBits < 4) begin
        bits0 = {bits0[2:0], oDai[0][0]};
        bits1 = {bits1[2:0], oDai[0][1]};
        nBits++;
      end
      prevLat = oLat[0];
    end
    checkOutput("three_latches_seen", latN, 3);
    checkOutput("no_drq_in_blank_frames", drqEarly, 0);
    checkOutput("frame3_chain0_bits", bits0, 4'b0101);
    checkOutput("frame3_chain1_bits", bits1, 4'b1010);

    // Address-pattern data: frame timing on dut0, overrun and skipped frame on dut1
    doReset(1);
    tA = -1; tL = -1; tO = -1; tA2 = -1; prevAddr1 = '0;
    for (int cyc = 0; cyc <= 800; cyc++) begin
      applyStimulus(1'b1);
      if (tA < 0 && oAddr[0] != '0) tA = cyc;
      if (tL < 0 && oLat[0]) tL = cyc;
      if (tO < 0 && oOvr[1]) tO = cyc;
      if (tO >= 0 && tA2 < 0 && prevAddr1 == '0 && oAddr[1] == AW'(C - 1)) tA2 = cyc;
      prevAddr1 = oAddr[1];
    end
    checkOutput("addr_entry_cycle", tA, 0);
    // ADDR entry to IDLE re-entry spans 322 cycles; the latch is the second-to-last of them
    checkOutput("lat_offset_from_addr", tL - tA, 320);
    checkOutput("overrun_at_2nd_count0", tO - tA, 300);
    checkOutput("next_frame_at_3rd_count0", tA2 - tA, 600);

    // Enable dropped 100 cycles into a frame: frame completes, then silence
    doReset(1);
    repeat (100) applyStimulus(1'b1);
    found = 1'b0;
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      applyStimulus(1'b0);
      if (oLat[0]) found = 1'b1;
    end
    checkOutput("lat_after_en_drop", found, 1);
    clkSeen = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      applyStimulus(1'b0);
      if (oClk[0] || oClk[1]) clkSeen++;
    end
    checkOutput("no_clk_while_disabled", clkSeen, 0);

    // Frames resume; reset lands in the middle of a shift
    found = 1'b0;
    for (int cyc = 0; cyc < 600 && !found; cyc++) begin
      applyStimulus(1'b1);
      if (oClk[0]) found = 1'b1;
    end
    checkOutput("shift_reached_after_resume", found, 1);
    doReset(2);
    tR = -1;
    for (int cyc = 0; cyc < 900 && tR < 0; cyc++) begin
      applyStimulus(1'b1);
      if (cyc == 0) checkOutput("ready_no_blank_after_release", oReady[1], 1);
      if (oReady[0]) tR = cyc;
    end
    checkOutput("ready_after_blank_frames", tR, 721);

    // Random enable toggling over random framebuffer contents
    enR = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if ($urandom_range(0, 249) == 0) enR = ~enR;
      applyStimulus(enR);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
